// File: rtl/spart_driver.sv
// spart_driver: configures a SPART peripheral's baud divisor, then echoes
// every received byte back to the transmitter. One bus access per state;
// bus outputs are decoded from the current state only.
module spart_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] db_out,
  input  logic [7:0] db_in,
  output logic [7:0] rx_byte,
  output logic [7:0] echo_cnt,
  output logic       cfg_done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CFG_LO   = 3'd1;
  localparam logic [2:0] CFG_HI   = 3'd2;
  localparam logic [2:0] POLL_RX  = 3'd3;
  localparam logic [2:0] READ_RX  = 3'd4;
  localparam logic [2:0] POLL_TX  = 3'd5;
  localparam logic [2:0] WRITE_TX = 3'd6;

  localparam logic [1:0] A_BUF    = 2'b00;
  localparam logic [1:0] A_STATUS = 2'b01;
  localparam logic [1:0] A_DIV_LO = 2'b10;
  localparam logic [1:0] A_DIV_HI = 2'b11;

  logic [2:0] state_q, state_d;
  logic [1:0] cfg_q;
  logic [7:0] rx_byte_q;
  logic [7:0] echo_cnt_q;

  // 16x oversample divisor for a 50 MHz clock
  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   divisor = 16'h028B;
      2'b01:   divisor = 16'h0145;
      2'b10:   divisor = 16'h00A3;
      default: divisor = 16'h0051;
    endcase
  endfunction

  // Next-state selection; a baud change is only honoured between echoes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = CFG_LO;
      CFG_LO:   state_d = CFG_HI;
      CFG_HI:   state_d = POLL_RX;
      POLL_RX: begin
        if (br_cfg != cfg_q)  state_d = CFG_LO;
        else if (db_in[1])    state_d = READ_RX;
      end
      READ_RX:  state_d = POLL_TX;
      POLL_TX:  if (db_in[0]) state_d = WRITE_TX;
      WRITE_TX: state_d = (br_cfg != cfg_q) ? CFG_LO : POLL_RX;
      default:  state_d = IDLE;
    endcase
  end

  // State, latched config, captured byte and echo counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cfg_q      <= 2'b00;
      rx_byte_q  <= 8'h00;
      echo_cnt_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == CFG_LO)   cfg_q      <= br_cfg;
      if (state_q == READ_RX)  rx_byte_q  <= db_in;
      if (state_q == WRITE_TX) echo_cnt_q <= echo_cnt_q + 8'd1;
    end
  end

  // Bus decode; CFG_LO uses br_cfg directly since cfg_q is loaded at its end
  always_comb begin
    iocs     = 1'b1;
    iorw     = 1'b1;
    ioaddr   = A_STATUS;
    db_out   = 8'h00;
    cfg_done = 1'b1;
    case (state_q)
      CFG_LO: begin
        iorw     = 1'b0;
        ioaddr   = A_DIV_LO;
        db_out   = divisor(br_cfg)[7:0];
        cfg_done = 1'b0;
      end
      CFG_HI: begin
        iorw     = 1'b0;
        ioaddr   = A_DIV_HI;
        db_out   = divisor(cfg_q)[15:8];
        cfg_done = 1'b0;
      end
      POLL_RX, POLL_TX: ;
      READ_RX:  ioaddr = A_BUF;
      WRITE_TX: begin
        iorw   = 1'b0;
        ioaddr = A_BUF;
        db_out = rx_byte_q;
      end
      default: begin
        iocs     = 1'b0;
        iorw     = 1'b0;
        ioaddr   = A_BUF;
        cfg_done = 1'b0;
      end
    endcase
  end

  assign rx_byte  = rx_byte_q;
  assign echo_cnt = echo_cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a small peripheral model answers reads, and every
// expected echo byte is queued when offered and checked when written back.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       iocs, iorw, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] db_out, db_in, rx_byte, echo_cnt;

  logic       rda, tbr;
  logic [7:0] rx_data;
  logic [7:0] exp_cnt;
  logic [7:0] sb_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  always #10 clk = ~clk;

  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .db_out(db_out),
    .db_in(db_in), .rx_byte(rx_byte), .echo_cnt(echo_cnt),
    .cfg_done(cfg_done)
  );

  // Peripheral read model; upper status bits carry junk that must be ignored
  always_comb begin
    db_in = 8'h00;
    if (iocs && iorw) begin
      if (ioaddr == 2'b01)      db_in = {6'b101101, rda, tbr};
      else if (ioaddr == 2'b00) db_in = rx_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic rw,
                         input logic [1:0] a, input logic [7:0] d, input logic cd);
    chk({tag, "_bus"}, {iocs, iorw, ioaddr, db_out, cfg_done},
        {cs, rw, a, d, cd});
  endtask

  // Advance one cycle and act as the write-side scoreboard
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (iocs && !iorw && ioaddr == 2'b00) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("echo_data", db_out, e);
        chk("echo_cnt_pre", echo_cnt, exp_cnt);
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  endtask

  // One echo starting in POLL_RX; br_cfg is changed while in POLL_TX
  task automatic do_echo(input logic [7:0] b, input int wait_n,
                         input logic [1:0] new_cfg, input bit detail);
    rda = 1'b1; tbr = 1'b0; rx_data = b;
    sb_q.push_back(b);
    step();
    if (detail) chk_bus("read_rx", 1, 1, 2'b00, 8'h00, 1);
    rda = 1'b0;
    step();
    if (detail) begin
      chk_bus("poll_tx", 1, 1, 2'b01, 8'h00, 1);
      chk("rx_byte", rx_byte, b);
    end
    br_cfg = new_cfg;
    for (int i = 0; i < wait_n; i++) begin
      step();
      chk_bus("tbr_wait", 1, 1, 2'b01, 8'h00, 1);
    end
    tbr = 1'b1;
    step();
    if (detail) chk_bus("write_tx", 1, 0, 2'b00, b, 1);
    tbr = 1'b0;
    step();
    if (detail) chk("echo_cnt_post", echo_cnt, exp_cnt);
  endtask

  initial begin
    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rx_data = 8'h00;
    exp_cnt = 8'h00;

    // Reset state
    step(); step();
    chk_bus("reset", 0, 0, 2'b00, 8'h00, 0);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_echo_cnt", echo_cnt, 8'h00);

    // Release and configure at 9600
    rst = 1'b1;
    chk_bus("idle", 0, 0, 2'b00, 8'h00, 0);
    step(); chk_bus("cfg_lo_9600", 1, 0, 2'b10, 8'h45, 0);
    step(); chk_bus("cfg_hi_9600", 1, 0, 2'b11, 8'h01, 0);
    step(); chk_bus("poll_rx", 1, 1, 2'b01, 8'h00, 1);
    step(); chk_bus("poll_rx_hold", 1, 1, 2'b01, 8'h00, 1);

    // Basic echo, earliest latency
    do_echo(8'h5A, 0, 2'b01, 1'b1);
    chk_bus("back_to_poll_rx", 1, 1, 2'b01, 8'h00, 1);

    // Transmitter busy for 10 cycles
    do_echo(8'hC3, 10, 2'b01, 1'b1);
    chk_bus("after_wait", 1, 1, 2'b01, 8'h00, 1);

    // Baud change during a pending echo: echo first, then reconfigure
    do_echo(8'h3C, 2, 2'b11, 1'b1);
    chk_bus("cfg_lo_38400", 1, 0, 2'b10, 8'h51, 0);
    step(); chk_bus("cfg_hi_38400", 1, 0, 2'b11, 8'h00, 0);
    step(); chk_bus("poll_rx_38400", 1, 1, 2'b01, 8'h00, 1);

    // Fill up to 256 echoes total
    for (int i = 0; i < 253; i++)
      do_echo(8'($urandom_range(0, 255)), 0, 2'b11, 1'b0);
    chk("echo_cnt_wrap", echo_cnt, 8'h00);
    chk("echo_cnt_model", echo_cnt, exp_cnt);

    // Reset in READ_RX: access aborted, no write afterwards
    rda = 1'b1; rx_data = 8'hA7;
    step(); chk_bus("pre_abort_read", 1, 1, 2'b00, 8'h00, 1);
    rst = 1'b0; rda = 1'b0; tbr = 1'b1;
    step();
    exp_cnt = 8'h00;
    chk_bus("abort_idle", 0, 0, 2'b00, 8'h00, 0);
    chk("abort_rx_byte", rx_byte, 8'h00);
    chk("abort_echo_cnt", echo_cnt, 8'h00);
    rst = 1'b1;
    step(); chk_bus("restart_cfg_lo", 1, 0, 2'b10, 8'h51, 0);
    for (int i = 0; i < 6; i++) step();
    chk_bus("restart_poll_rx", 1, 1, 2'b01, 8'h00, 1);
    chk("no_write_after_abort", echo_cnt, 8'h00);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
